gshare_predictor: RTL and testbench

Global-history (gshare) direction predictor that produces the `global_prediction` input of the tournament chooser. It sits in the fetch stage: it predicts taken/not-taken for the current IF PC and hands the PHT index down the pipeline. It is trained at the EX stage when the branch or jump resolves. Its pattern history table (PHT) holds 2-bit saturating counters indexed by PC XOR global history.

---
 rtl/rv32i_types.sv | 24 ++
 rtl/bp_pattern_table.sv | 34 +++
 rtl/gshare_predictor.sv | 76 +++++++
 tb/tb_gshare_predictor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types; holds the branch-predictor counter type and its
// saturating-update helper.
package rv32i_types;

    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_SNT = 2'b00;
    localparam bp_ctr_t BP_WNT = 2'b01;
    localparam bp_ctr_t BP_WT  = 2'b10;
    localparam bp_ctr_t BP_ST  = 2'b11;

    // Counters saturate at both ends so a long run never flips the prediction.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != BP_ST) result = ctr + 2'b01;
        end else begin
            if (ctr != BP_SNT) result = ctr - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_pattern_table.sv
// Pattern history table: 2^IDX_W two-bit saturating counters with one
// combinational read port and one saturating-update write port.
module bp_pattern_table
    import rv32i_types::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bp_ctr_t          o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    bp_ctr_t r_pht [DEPTH];

    // No bypass: a same-cycle read of the entry being trained sees the old value.
    assign o_rd_ctr = r_pht[i_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pht[i] <= BP_WNT;
            end
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= bp_ctr_next(r_pht[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes the PHT.
// Define GSHARE_SPEC_HISTORY_EN to add a speculative GHR with mispredict repair.
module gshare_predictor
    import rv32i_types::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    input  logic             if_valid,
    input  logic             if_stall,
    output logic             global_prediction,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispredict
);

    logic [IDX_W-1:0] r_ghr;
    logic [IDX_W-1:0] w_ghr_next;
    logic [IDX_W-1:0] w_ghr_view;
    bp_ctr_t          w_rd_ctr;

    assign w_ghr_next = {r_ghr[IDX_W-2:0], upd_taken};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= w_ghr_next;
        end
    end

`ifdef GSHARE_SPEC_HISTORY_EN
    logic [IDX_W-1:0] r_spec_ghr;
    logic             w_unused_pc;

    // Repair from the resolved outcome takes priority over speculative growth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spec_ghr <= '0;
        end else if (upd_valid && upd_mispredict) begin
            r_spec_ghr <= w_ghr_next;
        end else if (if_valid && !if_stall) begin
            r_spec_ghr <= {r_spec_ghr[IDX_W-2:0], global_prediction};
        end
    end

    assign w_ghr_view  = r_spec_ghr;
    assign w_unused_pc = &{1'b0, if_pc[31:IDX_W+2], if_pc[1:0]};
`else
    logic w_unused_pc;

    assign w_ghr_view  = r_ghr;
    assign w_unused_pc = &{1'b0, if_pc[31:IDX_W+2], if_pc[1:0],
                           if_valid, if_stall, upd_mispredict};
`endif

    assign pred_idx          = if_pc[IDX_W+1:2] ^ w_ghr_view;
    assign global_prediction = w_rd_ctr[1];

    bp_pattern_table #(
        .IDX_W (IDX_W)
    ) u_pht (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (pred_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (upd_valid),
        .i_wr_idx   (upd_idx),
        .i_wr_taken (upd_taken)
    );

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios then random
// traffic, all compared against a behavioural history/counter model.
module tb_gshare_predictor;

   localparam int IDX_W = 8;
   localparam int unsigned MASK = (1 << IDX_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [31:0]      if_pc;
   logic             if_valid;
   logic             if_stall;
   logic             global_prediction;
   logic [IDX_W-1:0] pred_idx;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_taken;
   logic             upd_mispredict;

   int checks = 0;
   int errors = 0;

   int unsigned modelPht [1 << IDX_W];
   int unsigned modelGhr;
   int unsigned modelSpec;

   logic        obsPred;
   logic [7:0]  obsIdx;

   gshare_predictor #(
      .IDX_W (IDX_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .if_pc             (if_pc),
      .if_valid          (if_valid),
      .if_stall          (if_stall),
      .global_prediction (global_prediction),
      .pred_idx          (pred_idx),
      .upd_valid         (upd_valid),
      .upd_idx           (upd_idx),
      .upd_taken         (upd_taken),
      .upd_mispredict    (upd_mispredict)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // The history that forms the index: speculative when that feature is built in.
   function automatic int unsigned viewGhr();
`ifdef GSHARE_SPEC_HISTORY_EN
      return modelSpec;
`else
      return modelGhr;
`endif
   endfunction

   // A PC that lands on the requested PHT entry under the current history.
   function automatic logic [31:0] pcFor(input int unsigned idx);
      return ((idx ^ viewGhr()) & MASK) << 2;
   endfunction

   task automatic modelReset();
      for (int i = 0; i <= int'(MASK); i++) modelPht[i] = 1;
      modelGhr  = 0;
      modelSpec = 0;
   endtask

   // Advances the model by one clock using the inputs of the cycle just ending.
   task automatic modelClock(input logic ifv, input logic stl, input logic uv,
                             input int unsigned uidx, input logic ut, input logic um,
                             input logic predNow);
      int unsigned newGhr;
      newGhr = ((modelGhr << 1) | int'(ut)) & MASK;
      if (uv) begin
         if (ut) modelPht[uidx] = (modelPht[uidx] == 3) ? 3 : modelPht[uidx] + 1;
         else    modelPht[uidx] = (modelPht[uidx] == 0) ? 0 : modelPht[uidx] - 1;
      end
`ifdef GSHARE_SPEC_HISTORY_EN
      if (uv && um) modelSpec = newGhr;
      else if (ifv && !stl) modelSpec = ((modelSpec << 1) | int'(predNow)) & MASK;
`else
      if (um && 1'b0) modelSpec = 0;
      if (ifv && stl && 1'b0) modelSpec = 0;
`endif
      if (uv) modelGhr = newGhr;
   endtask

   // One clock of stimulus: drive, check at the falling edge, clock the model.
   task automatic applyStimulus(input logic [31:0] pc, input logic ifv, input logic stl,
                                input logic uv, input int unsigned uidx, input logic ut,
                                input logic um);
      int unsigned expIdx;
      logic        expPred;
      if_pc          = pc;
      if_valid       = ifv;
      if_stall       = stl;
      upd_valid      = uv;
      upd_idx        = uidx[7:0];
      upd_taken      = ut;
      upd_mispredict = um;
      @(negedge clk);
      expIdx  = ((pc >> 2) & MASK) ^ viewGhr();
      expPred = (modelPht[expIdx] >= 2);
      obsPred = global_prediction;
      obsIdx  = pred_idx;
      checkOutput("pred_idx", {24'd0, pred_idx}, expIdx);
      checkOutput("prediction", {31'd0, global_prediction}, {31'd0, expPred});
      @(posedge clk);
      modelClock(ifv, stl, uv, uidx, ut, um, expPred);
      #1;
   endtask

   // Reset is dropped and raised mid-cycle, possibly while an update is being driven.
   task automatic doReset();
      #2 rst_n = 1'b0;
      modelReset();
      @(negedge clk);
      checkOutput("reset pred", {31'd0, global_prediction}, 32'd0);
      checkOutput("reset idx", {24'd0, pred_idx}, (if_pc >> 2) & MASK);
      @(posedge clk);
      #1;
      if_valid  = 1'b0;
      upd_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      if_pc          = 32'd0;
      if_valid       = 1'b0;
      if_stall       = 1'b0;
      upd_valid      = 1'b0;
      upd_idx        = '0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      doReset();

      // Reset state seen through a real fetch.
      applyStimulus(32'h100, 1, 0, 0, 0, 0, 0);
      checkOutput("post-reset pred", {31'd0, obsPred}, 32'd0);
      checkOutput("post-reset idx", {24'd0, obsIdx}, 32'h40);

      // Training entry 0x40 up to strongly taken.
      applyStimulus(32'h0, 0, 0, 1, 'h40, 1, 0);
      applyStimulus(32'h0, 0, 0, 1, 'h40, 1, 0);
      applyStimulus(32'h10C, 0, 0, 0, 0, 0, 0);
`ifndef GSHARE_SPEC_HISTORY_EN
      checkOutput("trained idx", {24'd0, obsIdx}, 32'h40);
      checkOutput("trained pred", {31'd0, obsPred}, 32'd1);
`endif

      // Saturation at the bottom, read back each cycle.
      for (int i = 0; i < 5; i++) applyStimulus(pcFor('h10), 0, 0, 1, 'h10, 0, 0);
      applyStimulus(pcFor('h10), 0, 0, 1, 'h10, 1, 0);
      applyStimulus(pcFor('h10), 0, 0, 0, 0, 0, 0);
      checkOutput("sat low pred", {31'd0, obsPred}, 32'd0);
      applyStimulus(pcFor('h10), 0, 0, 1, 'h10, 1, 0);
      applyStimulus(pcFor('h10), 0, 0, 0, 0, 0, 0);

      // Same-cycle read and update of one entry.
      applyStimulus(pcFor('h22), 1, 0, 1, 'h22, 1, 0);
      checkOutput("collision old", {31'd0, obsPred}, 32'd0);
      applyStimulus(pcFor('h22), 0, 0, 0, 0, 0, 0);
      checkOutput("collision new", {31'd0, obsPred}, 32'd1);

      // History wrap: the mispredict flag keeps both histories aligned.
      for (int i = 0; i < 9; i++) applyStimulus(32'h0, 0, 0, 1, 'h77, 1, 1);
      applyStimulus(32'h0, 0, 0, 0, 0, 0, 0);
      checkOutput("ghr all ones", {24'd0, obsIdx}, 32'hFF);
      applyStimulus(32'h0, 0, 0, 1, 'h77, 0, 1);
      applyStimulus(32'h0, 0, 0, 0, 0, 0, 0);
      checkOutput("ghr wrap", {24'd0, obsIdx}, 32'hFE);

      // Speculative history growth and mispredict repair.
      doReset();
      applyStimulus(32'h0, 0, 0, 1, 'h55, 1, 1);
      applyStimulus(32'h0, 0, 0, 1, 'h55, 1, 1);
      for (int i = 0; i < 8; i++) applyStimulus(32'h0, 0, 0, 1, 'h99, 0, 1);
      applyStimulus(32'h0, 0, 0, 0, 0, 0, 0);
      checkOutput("ghr cleared", {24'd0, obsIdx}, 32'h00);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(pcFor('h55), 1, 0, 0, 0, 0, 0);
         checkOutput("spec taken pred", {31'd0, obsPred}, 32'd1);
      end
      applyStimulus(32'h0, 0, 0, 0, 0, 0, 0);
`ifdef GSHARE_SPEC_HISTORY_EN
      checkOutput("spec ghr", {24'd0, obsIdx}, 32'h07);
`else
      checkOutput("committed only", {24'd0, obsIdx}, 32'h00);
`endif
      applyStimulus(32'h0, 0, 0, 1, 'h99, 0, 1);
      applyStimulus(32'h0, 0, 0, 0, 0, 0, 0);
      checkOutput("repaired ghr", {24'd0, obsIdx}, 32'h00);

      // Random traffic with occasional asynchronous resets.
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] pc;
         int unsigned uidx;
         int unsigned pick;
         pick = $urandom_range(0, 3);
         uidx = (pick == 0) ? 'h10 : (pick == 1) ? 'h22 : (pick == 2) ? 'h40 : $urandom_range(0, MASK);
         pc   = ($urandom_range(0, 1) == 1) ? pcFor(uidx) : $urandom;
         if ($urandom_range(0, 199) == 0) begin
            if_pc     = pc;
            upd_valid = 1'b1;
            upd_idx   = uidx[7:0];
            doReset();
         end else begin
            applyStimulus(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)), uidx, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
